mem_arbiter: RTL and testbench

- Two-port arbiter/sequencer for the shared single-port 2048 x 16 data memory (combinational read, write on the clock edge).
- Arbitrates between requester 0 (fetch side) and requester 1 (load/store side) with round-robin priority.
- Provides a lock for atomic read-modify-write sequences, with a lock timeout.
- Registers read data so each requester sees a one-cycle read latency.

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for a shared single-port data memory, with lock and lock timeout.
// Optional build macro MEM_ARB_CONFLICT_CNT_EN adds a saturating conflict_cnt output.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic                  p0_lock,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic                  p1_lock,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
`ifdef MEM_ARB_CONFLICT_CNT_EN
    output logic [15:0]           conflict_cnt,
`endif
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    // state | meaning
    // IDLE  | no owner, round-robin between requesters
    // OWN0  | port 0 holds the lock, only port 0 may be granted
    // OWN1  | port 1 holds the lock, only port 1 may be granted
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_MAX - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;
    logic                  w_last_nxt;
    logic [CNT_WIDTH-1:0]  r_lock_cnt;
    logic [CNT_WIDTH-1:0]  w_lock_cnt_nxt;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  r_p0_rvalid;
    logic                  r_p1_rvalid;
    logic [DATA_WIDTH-1:0] r_p0_rdata;
    logic [DATA_WIDTH-1:0] r_p1_rdata;

    // Grants are gated by rst_n so an asserted reset silences the memory port at once.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (p0_req && p1_req) begin
                    if (r_last_grant) w_gnt0 = 1'b1;
                    else              w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = p0_req;
                    w_gnt1 = p1_req;
                end
            end
            ST_OWN0: w_gnt0 = p0_req;
            ST_OWN1: w_gnt1 = p1_req;
            default: ;
        endcase
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_last_nxt     = r_last_grant;
        if (w_gnt0)      w_last_nxt = 1'b0;
        else if (w_gnt1) w_last_nxt = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                w_lock_cnt_nxt = '0;
                if (w_gnt0 && p0_lock)      w_state_nxt = ST_OWN0;
                else if (w_gnt1 && p1_lock) w_state_nxt = ST_OWN1;
            end
            ST_OWN0: begin
                if (!p0_lock) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == LOCK_LAST) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                    w_last_nxt     = 1'b0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_WIDTH'(1);
                end
            end
            ST_OWN1: begin
                if (!p1_lock) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == LOCK_LAST) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                    w_last_nxt     = 1'b1;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_gnt0 & ~p0_we;
            r_p1_rvalid <= w_gnt1 & ~p1_we;
            if (w_gnt0 && !p0_we) r_p0_rdata <= mem_read_data;
            if (w_gnt1 && !p1_we) r_p1_rdata <= mem_read_data;
        end
    end

    assign p0_gnt       = w_gnt0;
    assign p1_gnt       = w_gnt1;
    assign p0_rvalid    = r_p0_rvalid;
    assign p1_rvalid    = r_p1_rvalid;
    assign p0_rdata     = r_p0_rdata;
    assign p1_rdata     = r_p1_rdata;
    assign mem_write_en = (w_gnt0 & p0_we) | (w_gnt1 & p1_we);
    assign mem_address  = w_gnt0 ? p0_addr  : (w_gnt1 ? p1_addr  : '0);
    assign mem_data_in  = w_gnt0 ? p0_wdata : (w_gnt1 ? p1_wdata : '0);

`ifdef MEM_ARB_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = (p0_req & ~w_gnt0) | (p1_req & ~w_gnt1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed vector table, hand sequences for lock/timeout/reset, and random
// traffic checked against a transaction-level reference model. Honours MEM_ARB_CONFLICT_CNT_EN.
module tb_mem_arbiter;

    localparam int LOCK_MAX = 16;

    typedef struct {
        logic        r0, w0, l0;
        logic [10:0] a0;
        logic [15:0] d0;
        logic        r1, w1, l1;
        logic [10:0] a1;
        logic [15:0] d1;
    } req_t;

    typedef struct {
        req_t        in;
        int          g;
        logic        rv0;
        logic        rv1;
        logic [15:0] rd;
    } tvec_t;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
    logic [10:0] p0_addr;
    logic [15:0] p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [10:0] p1_addr;
    logic [15:0] p1_wdata, p1_rdata;
    logic        mem_write_en;
    logic [10:0] mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_read_data;
`ifdef MEM_ARB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    mem_arbiter #(
        .ADDR_WIDTH(11), .DATA_WIDTH(16), .LOCK_MAX(LOCK_MAX), .CNT_WIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
`ifdef MEM_ARB_CONFLICT_CNT_EN
        .conflict_cnt(conflict_cnt),
`endif
        .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 2048 x 16 memory attached to the arbiter.
    logic [15:0] mem_arr [0:2047];
    logic        fill_en;

    function automatic logic [15:0] fill_val(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    assign mem_read_data = mem_arr[mem_address];

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 2048; i++) mem_arr[i] <= fill_val(i);
        end else if (mem_write_en) begin
            mem_arr[mem_address] <= mem_data_in;
        end
    end

    // Reference model: who owns the memory, how long it has owned it, and who went last.
    logic [15:0] ref_mem [0:2047];
    int          m_owner;
    int          m_last;
    int          m_held;
    int          m_conf;
    logic        m_rv [2];
    logic [15:0] m_rd [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input bit r0, input bit w0, input bit l0, input int a0, input int d0,
                                input bit r1, input bit w1, input bit l1, input int a1, input int d1);
        req_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = 11'(a0); v.d0 = 16'(d0);
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = 11'(a1); v.d1 = 16'(d1);
        return v;
    endfunction

    function automatic int model_grant(input req_t v);
        if (m_owner == 0) return v.r0 ? 0 : -1;
        if (m_owner == 1) return v.r1 ? 1 : -1;
        if (v.r0 && v.r1) return (m_last == 0) ? 1 : 0;
        if (v.r0) return 0;
        if (v.r1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_held  = 0;
        m_conf  = 0;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = '0;   m_rd[1] = '0;
    endtask

    task automatic model_step(input req_t v, input int g);
        logic [10:0] a;
        logic        we, lk;
        if (((v.r0 && g != 0) || (v.r1 && g != 1)) && m_conf < 65535) m_conf++;
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (g >= 0) begin
            a  = (g == 0) ? v.a0 : v.a1;
            we = (g == 0) ? v.w0 : v.w1;
            if (we) ref_mem[a] = (g == 0) ? v.d0 : v.d1;
            else begin
                m_rv[g] = 1'b1;
                m_rd[g] = ref_mem[a];
            end
            m_last = g;
        end
        if (m_owner < 0) begin
            lk = (g == 0) ? v.l0 : v.l1;
            if (g >= 0 && lk) begin
                m_owner = g;
                m_held  = 0;
            end
        end else begin
            lk = (m_owner == 0) ? v.l0 : v.l1;
            if (!lk) m_owner = -1;
            else begin
                m_held++;
                if (m_held == LOCK_MAX) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic drive(input req_t v);
        p0_req = v.r0; p0_we = v.w0; p0_lock = v.l0; p0_addr = v.a0; p0_wdata = v.d0;
        p1_req = v.r1; p1_we = v.w1; p1_lock = v.l1; p1_addr = v.a1; p1_wdata = v.d1;
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic run_cycle(input req_t v, output int act_g);
        int g;
        drive(v);
        g = model_grant(v);
        #2;
        act_g = p0_gnt ? 0 : (p1_gnt ? 1 : -1);
        chk("gnt0", p0_gnt, g == 0);
        chk("gnt1", p1_gnt, g == 1);
        chk("mem_we", mem_write_en, (g == 0) ? v.w0 : ((g == 1) ? v.w1 : 1'b0));
        chk("mem_addr", mem_address, (g == 0) ? v.a0 : ((g == 1) ? v.a1 : 11'd0));
        chk("mem_din", mem_data_in, (g == 0) ? v.d0 : ((g == 1) ? v.d1 : 16'd0));
        @(posedge clk);
        model_step(v, g);
        #1;
        chk("rvalid0", p0_rvalid, m_rv[0]);
        chk("rvalid1", p1_rvalid, m_rv[1]);
        chk("rdata0", p0_rdata, m_rd[0]);
        chk("rdata1", p1_rdata, m_rd[1]);
`ifdef MEM_ARB_CONFLICT_CNT_EN
        chk("conflict_cnt", conflict_cnt, 32'(m_conf));
`endif
    endtask

    task automatic hand(input string nm, input req_t v, input int eg);
        int g;
        run_cycle(v, g);
        chk(nm, g, eg);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_gnt0"}, p0_gnt, 1'b0);
        chk({nm, "_gnt1"}, p1_gnt, 1'b0);
        chk({nm, "_rv0"}, p0_rvalid, 1'b0);
        chk({nm, "_rv1"}, p1_rvalid, 1'b0);
        chk({nm, "_rd0"}, p0_rdata, 16'd0);
        chk({nm, "_rd1"}, p1_rdata, 16'd0);
        chk({nm, "_mem_we"}, mem_write_en, 1'b0);
        chk({nm, "_mem_addr"}, mem_address, 11'd0);
`ifdef MEM_ARB_CONFLICT_CNT_EN
        chk({nm, "_conflict"}, conflict_cnt, 16'd0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(mk(0,0,0,0,0, 0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    tvec_t tbl [11];

    initial begin
        int   g;
        int   found;
        req_t cur;
        int   prev_g;

        fill_en = 1'b1;
        rst_n   = 1'b0;
        drive(mk(0,0,0,0,0, 0,0,0,0,0));
        @(posedge clk);
        #1;
        fill_en = 1'b0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = fill_val(i);

        tbl[0]  = '{mk(0,0,0,0,0,            1,1,0,'h005,'h1234),  1, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{mk(1,0,0,'h005,0,        0,0,0,0,0),           0, 1'b1, 1'b0, 16'h1234};
        tbl[2]  = '{mk(0,0,0,0,0,            0,0,0,0,0),          -1, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{mk(0,0,0,0,0,            1,1,0,'h7FF,'hBEEF),  1, 1'b0, 1'b0, 16'h0000};
        tbl[4]  = '{mk(1,0,0,'h7FF,0,        0,0,0,0,0),           0, 1'b1, 1'b0, 16'hBEEF};
        tbl[5]  = '{mk(1,0,0,'h005,0,        1,0,0,'h7FF,0),       1, 1'b0, 1'b1, 16'hBEEF};
        tbl[6]  = '{mk(1,0,0,'h005,0,        1,0,0,'h7FF,0),       0, 1'b1, 1'b0, 16'h1234};
        tbl[7]  = '{mk(0,0,0,0,0,            1,0,0,'h7FF,0),       1, 1'b0, 1'b1, 16'hBEEF};
        tbl[8]  = '{mk(1,1,0,'h010,'hAAAA,   1,1,0,'h010,'h5555),  0, 1'b0, 1'b0, 16'h0000};
        tbl[9]  = '{mk(1,0,0,'h010,0,        1,1,0,'h010,'h5555),  1, 1'b0, 1'b0, 16'h0000};
        tbl[10] = '{mk(1,0,0,'h010,0,        0,0,0,0,0),           0, 1'b1, 1'b0, 16'h5555};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            run_cycle(tbl[i].in, g);
            chk($sformatf("tbl%0d_gnt", i), g, tbl[i].g);
            chk($sformatf("tbl%0d_rv0", i), p0_rvalid, tbl[i].rv0);
            chk($sformatf("tbl%0d_rv1", i), p1_rvalid, tbl[i].rv1);
            if (tbl[i].rv0) chk($sformatf("tbl%0d_rd0", i), p0_rdata, tbl[i].rd);
            if (tbl[i].rv1) chk($sformatf("tbl%0d_rd1", i), p1_rdata, tbl[i].rd);
        end

        // Round-robin from reset: port 0 first, then alternating.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle(mk(1,0,0,'h005,0, 1,0,0,'h7FF,0), g);
            chk($sformatf("rr%0d_gnt", i), g, i % 2);
            if (i % 2 == 0) chk($sformatf("rr%0d_rd0", i), p0_rdata, 16'h1234);
            else            chk($sformatf("rr%0d_rd1", i), p1_rdata, 16'hBEEF);
        end

        // Locked read-modify-write by port 1 while port 0 waits.
        do_reset();
        hand("rmw_pre_w", mk(0,0,0,0,0,         1,1,0,'h010,'h0003), 1);
        hand("rmw_pre_r", mk(1,0,0,'h020,0,     0,0,0,0,0),          0);
        hand("rmw_rd",    mk(1,0,0,'h020,0,     1,0,1,'h010,0),      1);
        chk("rmw_rd_data", p1_rdata, 16'h0003);
        hand("rmw_wr",    mk(1,0,0,'h020,0,     1,1,1,'h010,'h0004), 1);
        hand("rmw_drop",  mk(1,0,0,'h020,0,     0,0,0,0,0),         -1);
        hand("rmw_p0",    mk(1,0,0,'h020,0,     0,0,0,0,0),          0);
        hand("rmw_chk",   mk(1,0,0,'h010,0,     0,0,0,0,0),          0);
        chk("rmw_result", p0_rdata, 16'h0004);

        // Lock timeout: port 0 never releases, port 1 keeps asking.
        do_reset();
        found = -1;
        for (int k = 0; k < 40; k++) begin
            run_cycle(mk(1,0,1,'h030,0, 1,0,0,'h031,0), g);
            if (k == 0) chk("to_first_gnt", g, 0);
            if (g == 1) begin
                found = k;
                break;
            end
        end
        chk("to_p1_gnt_cycle", found, 17);

        // Asynchronous reset in the middle of a read grant.
        do_reset();
        hand("ar_read", mk(1,0,0,'h005,0, 0,0,0,0,0), 0);
        chk("ar_rd0_pre", p0_rdata, 16'h1234);
        drive(mk(1,0,0,'h7FF,0, 0,0,0,0,0));
        #2;
        chk("ar_gnt_pre", p0_gnt, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("ar_now");
        @(posedge clk);
        #1;
        check_reset_outputs("ar_edge");
        drive(mk(0,0,0,0,0, 0,0,0,0,0));
        rst_n = 1'b1;
        model_reset();
        hand("ar_after", mk(0,0,0,0,0, 0,0,0,0,0), -1);

        // Random traffic obeying the hold-until-granted rule.
        do_reset();
        cur    = mk(0,0,0,0,0, 0,0,0,0,0);
        prev_g = -1;
        for (int n = 0; n < 600; n++) begin
            if (!(cur.r0 && prev_g != 0 && ($urandom % 16) != 0)) begin
                cur.r0 = (($urandom % 4) != 0);
                cur.w0 = $urandom % 2;
                cur.a0 = ($urandom % 2) ? 11'($urandom % 8) : 11'(11'h7F8 + 11'($urandom % 8));
                cur.d0 = 16'($urandom);
            end
            if (!(cur.r1 && prev_g != 1 && ($urandom % 16) != 0)) begin
                cur.r1 = (($urandom % 4) != 0);
                cur.w1 = $urandom % 2;
                cur.a1 = ($urandom % 2) ? 11'($urandom % 8) : 11'(11'h7F8 + 11'($urandom % 8));
                cur.d1 = 16'($urandom);
            end
            cur.l0 = cur.l0 ? (($urandom % 10) != 0) : (($urandom % 6) == 0);
            cur.l1 = cur.l1 ? (($urandom % 10) != 0) : (($urandom % 6) == 0);
            prev_g = model_grant(cur);
            run_cycle(cur, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
